addr_rf_sched: RTL and testbench
================================

ADDR_RF_SCHED -- requirements
Module: addr_rf_sched

Interface
REQ-001 SHALL have parameter IA_ROW, default 128: max input-activation rows/cols; position width PW = $clog2(IA_ROW)+1.
REQ-002 SHALL have parameter W_C_NUM, default 16: weight-column count; column index width CW = $clog2(W_C_NUM)+1.
REQ-003 SHALL have parameter W_C_LENGTH, default 64: max non-zeros per column; length width LW = $clog2(W_C_LENGTH)+1.
REQ-004 SHALL have ports: i_clk in 1, the single clock; i_rst_n in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: i_start in 1, job-start pulse; i_stride in 2, convolution stride; i_oh_num in PW, output rows; i_ow_num in PW, output cols; i_col_num in CW, weight columns to process.
REQ-006 SHALL have ports: o_col in CW, column index for the length-table lookup; i_col_len in LW, that column's non-zero count, returned combinationally.
REQ-007 SHALL have ports: o_rf_start out 1, AddrToRF start pulse; o_h in PW, o_w in PW, o_length in LW, AddrToRF operands; i_rf_finish in 1, AddrToRF completion.
REQ-008 SHALL have ports: o_busy out 1, job active; o_done out 1, job-complete pulse.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, NEXT, DONE.
REQ-010 SHALL, in IDLE on i_start=1, latch i_stride, i_oh_num, i_ow_num, i_col_num, clear col/oh/ow counters, and enter ISSUE next cycle; o_busy=1 from that cycle.
REQ-011 SHALL treat latched stride 0 as 1; o_h = oh*stride, o_w = ow*stride, truncated to PW bits.
REQ-012 SHALL, in ISSUE with i_col_len!=0, assert o_rf_start for exactly one cycle, register o_length=i_col_len, hold o_h/o_w/o_length stable until the next ISSUE, and enter WAIT.
REQ-013 SHALL, in ISSUE with i_col_len==0, skip the entire column: no o_rf_start, jump to the next column, reset oh/ow, go to NEXT.
REQ-014 SHALL remain in WAIT until i_rf_finish=1, then enter NEXT; i_rf_finish in any other state is ignored.
REQ-015 SHALL, in NEXT, advance in order ow innermost, then oh, then col; when the last (col, oh, ow) is consumed, enter DONE, otherwise ISSUE.
REQ-016 SHALL, in DONE, pulse o_done for one cycle, drop o_busy, and return to IDLE.
REQ-017 SHALL ignore i_start while o_busy=1.
REQ-018 SHALL, if any latched count (oh_num, ow_num, col_num) is 0, go IDLE->DONE directly with no o_rf_start.
REQ-019 SHALL achieve latency from i_rf_finish to the next o_rf_start of exactly 2 cycles (NEXT, ISSUE).

Reset
REQ-020 SHALL on i_rst_n=0 asynchronously force IDLE and all outputs and counters to 0, including mid-job; after release, idle until a new i_start.

Configuration
REQ-021 SHALL, with ADDR_RF_SCHED_PERF_EN defined, add o_busy_cycles out 32 (cycles with o_busy=1 in the last job) and o_issue_cnt out 16 (o_rf_start pulses in the last job), both cleared on job start and held after DONE.
REQ-022 SHALL, without ADDR_RF_SCHED_PERF_EN, omit these ports and counters entirely.

Structure
REQ-023 SHALL place the FSM state enum and the IA_ROW/W_C_NUM/W_C_LENGTH defaults in the shared accelerator package, alongside the existing header defines.
REQ-024 SHALL use one sub-module addr_rf_pos_cnt, the nested col/oh/ow counter with a last-position flag; the FSM stays in the top module.

Verification
REQ-025 SHALL cover: stride=1, oh=2, ow=3, col=1, len=10, finish 5 cycles after each start -> 6 starts with (h,w)=(0,0),(0,1),(0,2),(1,0),(1,1),(1,2), then one o_done.
REQ-026 SHALL cover: stride=2, oh=2, ow=2, col=1 -> (h,w)=(0,0),(0,2),(2,0),(2,2).
REQ-027 SHALL cover: col=3, lens {4,0,7}, oh=ow=1 -> exactly 2 starts with o_length 4 and 7, column 1 skipped.
REQ-028 SHALL cover: i_start re-pulsed during WAIT, plus a spurious i_rf_finish in ISSUE -> no extra starts, sequence unchanged.
REQ-029 SHALL cover: i_rst_n low during WAIT -> outputs 0 immediately; a new i_start gives a clean job from (0,0,0).
REQ-030 SHALL cover: oh_num=0 -> o_done 2 cycles after i_start, zero o_rf_start; with PERF_EN, o_issue_cnt=0.

Source files
------------

// File: rtl/addr_rf_sched_pkg.sv
// Shared accelerator package: size defaults and scheduler FSM state encodings.
package addr_rf_sched_pkg;

    localparam int unsigned IA_ROW_DEF     = 128;
    localparam int unsigned W_C_NUM_DEF    = 16;
    localparam int unsigned W_C_LENGTH_DEF = 64;

    typedef logic [2:0] sched_state_t;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StIssue = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StNext  = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

endpackage

// File: rtl/addr_rf_pos_cnt.sv
// Nested (col, oh, ow) position counter, ow innermost, with last-position and
// past-last-column flags.
module addr_rf_pos_cnt #(
    parameter int unsigned PW = 8,
    parameter int unsigned CW = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          step_i,
    input  logic          skip_i,
    input  logic [PW-1:0] oh_num_i,
    input  logic [PW-1:0] ow_num_i,
    input  logic [CW-1:0] col_num_i,
    output logic [CW-1:0] col_o,
    output logic [PW-1:0] oh_o,
    output logic [PW-1:0] ow_o,
    output logic          last_o,
    output logic          col_end_o
);

    logic [CW-1:0] col_q, col_d;
    logic [PW-1:0] oh_q, oh_d;
    logic [PW-1:0] ow_q, ow_d;
    logic          ow_wrap, oh_wrap;

    assign ow_wrap = (ow_q == ow_num_i - PW'(1));
    assign oh_wrap = (oh_q == oh_num_i - PW'(1));

    always_comb begin
        col_d = col_q;
        oh_d  = oh_q;
        ow_d  = ow_q;
        if (clr_i) begin
            col_d = '0;
            oh_d  = '0;
            ow_d  = '0;
        end else if (skip_i) begin
            col_d = col_q + CW'(1);
            oh_d  = '0;
            ow_d  = '0;
        end else if (step_i) begin
            if (!ow_wrap) begin
                ow_d = ow_q + PW'(1);
            end else begin
                ow_d = '0;
                if (!oh_wrap) begin
                    oh_d = oh_q + PW'(1);
                end else begin
                    oh_d  = '0;
                    col_d = col_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            oh_q  <= '0;
            ow_q  <= '0;
        end else begin
            col_q <= col_d;
            oh_q  <= oh_d;
            ow_q  <= ow_d;
        end
    end

    assign col_o     = col_q;
    assign oh_o      = oh_q;
    assign ow_o      = ow_q;
    assign last_o    = ow_wrap && oh_wrap && (col_q == col_num_i - CW'(1));
    // A skipped final column leaves col one past the end.
    assign col_end_o = (col_q >= col_num_i);

endmodule

// File: rtl/addr_rf_sched.sv
// Walks (col, oh, ow) and issues one AddrToRF job per position, skipping empty columns.
// Define ADDR_RF_SCHED_PERF_EN to add per-job busy-cycle and issue counters.
module addr_rf_sched
    import addr_rf_sched_pkg::*;
#(
    parameter int unsigned IA_ROW     = IA_ROW_DEF,
    parameter int unsigned W_C_NUM    = W_C_NUM_DEF,
    parameter int unsigned W_C_LENGTH = W_C_LENGTH_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic [1:0]                    i_stride,
    input  logic [$clog2(IA_ROW):0]       i_oh_num,
    input  logic [$clog2(IA_ROW):0]       i_ow_num,
    input  logic [$clog2(W_C_NUM):0]      i_col_num,
    output logic [$clog2(W_C_NUM):0]      o_col,
    input  logic [$clog2(W_C_LENGTH):0]   i_col_len,
    output logic                          o_rf_start,
    output logic [$clog2(IA_ROW):0]       o_h,
    output logic [$clog2(IA_ROW):0]       o_w,
    output logic [$clog2(W_C_LENGTH):0]   o_length,
    input  logic                          i_rf_finish,
    output logic                          o_busy,
    output logic                          o_done
`ifdef ADDR_RF_SCHED_PERF_EN
    ,
    output logic [31:0]                   o_busy_cycles,
    output logic [15:0]                   o_issue_cnt
`endif
);

    localparam int unsigned PW = $clog2(IA_ROW) + 1;
    localparam int unsigned CW = $clog2(W_C_NUM) + 1;
    localparam int unsigned LW = $clog2(W_C_LENGTH) + 1;

    sched_state_t  state_q, state_d;
    logic [1:0]    stride_q;
    logic [PW-1:0] oh_num_q, ow_num_q;
    logic [CW-1:0] col_num_q;
    logic          skip_q, busy_q, done_q, rf_start_q;
    logic [PW-1:0] h_q, w_q;
    logic [LW-1:0] length_q;

    logic          cnt_clr, cnt_step, cnt_skip;
    logic [CW-1:0] col;
    logic [PW-1:0] oh, ow;
    logic          pos_last, col_end;
    logic          start_ok, zero_job, issue;
    logic [1:0]    stride_eff;
    logic [PW-1:0] h_calc, w_calc;

    assign start_ok   = (state_q == StIdle) && i_start;
    assign zero_job   = (i_oh_num == '0) || (i_ow_num == '0) || (i_col_num == '0);
    assign issue      = (state_q == StIssue) && (i_col_len != '0);
    assign stride_eff = (stride_q == 2'd0) ? 2'd1 : stride_q;
    assign h_calc     = oh * {{(PW-2){1'b0}}, stride_eff};
    assign w_calc     = ow * {{(PW-2){1'b0}}, stride_eff};

    addr_rf_pos_cnt #(
        .PW (PW),
        .CW (CW)
    ) u_pos_cnt (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .clr_i     (cnt_clr),
        .step_i    (cnt_step),
        .skip_i    (cnt_skip),
        .oh_num_i  (oh_num_q),
        .ow_num_i  (ow_num_q),
        .col_num_i (col_num_q),
        .col_o     (col),
        .oh_o      (oh),
        .ow_o      (ow),
        .last_o    (pos_last),
        .col_end_o (col_end)
    );

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_step = 1'b0;
        cnt_skip = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_start) begin
                    cnt_clr = 1'b1;
                    state_d = zero_job ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (i_col_len != '0) begin
                    state_d = StWait;
                end else begin
                    cnt_skip = 1'b1;
                    state_d  = StNext;
                end
            end
            StWait: begin
                if (i_rf_finish) state_d = StNext;
            end
            StNext: begin
                // After a skip the counter already points at the next column.
                if (skip_q) begin
                    state_d = col_end ? StDone : StIssue;
                end else if (pos_last) begin
                    state_d = StDone;
                end else begin
                    cnt_step = 1'b1;
                    state_d  = StIssue;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            stride_q   <= '0;
            oh_num_q   <= '0;
            ow_num_q   <= '0;
            col_num_q  <= '0;
            skip_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rf_start_q <= 1'b0;
            h_q        <= '0;
            w_q        <= '0;
            length_q   <= '0;
        end else begin
            state_q    <= state_d;
            skip_q     <= cnt_skip;
            done_q     <= (state_q == StDone);
            rf_start_q <= issue;
            if (start_ok) begin
                stride_q  <= i_stride;
                oh_num_q  <= i_oh_num;
                ow_num_q  <= i_ow_num;
                col_num_q <= i_col_num;
                busy_q    <= 1'b1;
            end else if (state_q == StDone) begin
                busy_q <= 1'b0;
            end
            if (issue) begin
                h_q      <= h_calc;
                w_q      <= w_calc;
                length_q <= i_col_len;
            end
        end
    end

`ifdef ADDR_RF_SCHED_PERF_EN
    logic [31:0] busy_cycles_q;
    logic [15:0] issue_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_cycles_q <= '0;
            issue_cnt_q   <= '0;
        end else if (start_ok) begin
            busy_cycles_q <= '0;
            issue_cnt_q   <= '0;
        end else begin
            if (busy_q) busy_cycles_q <= busy_cycles_q + 32'd1;
            if (issue)  issue_cnt_q   <= issue_cnt_q + 16'd1;
        end
    end

    assign o_busy_cycles = busy_cycles_q;
    assign o_issue_cnt   = issue_cnt_q;
`endif

    assign o_col      = col;
    assign o_rf_start = rf_start_q;
    assign o_h        = h_q;
    assign o_w        = w_q;
    assign o_length   = length_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_addr_rf_sched.sv
// Directed bench for addr_rf_sched; cycle numbers are counted from the i_start drive cycle.
module tb_addr_rf_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic [1:0] i_stride;
    logic [7:0] i_oh_num, i_ow_num;
    logic [4:0] i_col_num;
    logic [4:0] o_col;
    logic [6:0] i_col_len;
    logic       o_rf_start;
    logic [7:0] o_h, o_w;
    logic [6:0] o_length;
    logic       i_rf_finish;
    logic       o_busy, o_done;
`ifdef ADDR_RF_SCHED_PERF_EN
    logic [31:0] o_busy_cycles;
    logic [15:0] o_issue_cnt;
`endif

    logic [6:0] len_tab [32];
    assign i_col_len = len_tab[o_col];

    always #5 clk = ~clk;

    addr_rf_sched u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (i_start),
        .i_stride      (i_stride),
        .i_oh_num      (i_oh_num),
        .i_ow_num      (i_ow_num),
        .i_col_num     (i_col_num),
        .o_col         (o_col),
        .i_col_len     (i_col_len),
        .o_rf_start    (o_rf_start),
        .o_h           (o_h),
        .o_w           (o_w),
        .o_length      (o_length),
        .i_rf_finish   (i_rf_finish),
        .o_busy        (o_busy),
        .o_done        (o_done)
`ifdef ADDR_RF_SCHED_PERF_EN
        ,
        .o_busy_cycles (o_busy_cycles),
        .o_issue_cnt   (o_issue_cnt)
`endif
    );

    int n_chk = 0;
    int n_bad = 0;
    int got_h[$], got_w[$], got_l[$], got_c[$], st_cyc[$];
    int exp_h[$], exp_w[$], exp_l[$], exp_c[$];
    int done_cnt, done_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts a job from a drive point (1 time unit after a rising edge) and answers
    // each o_rf_start with i_rf_finish 5 cycles later.
    task automatic run_job(input int st, input int oh, input int ow, input int cn, input bit poke);
        int cyc, fin_at, spur_at, tail;
        got_h.delete(); got_w.delete(); got_l.delete(); got_c.delete(); st_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        i_stride  = 2'(st);
        i_oh_num  = 8'(oh);
        i_ow_num  = 8'(ow);
        i_col_num = 5'(cn);
        i_start   = 1'b1;
        @(posedge clk); #1;
        cyc     = 1;
        fin_at  = -1;
        spur_at = poke ? 1 : -1;
        tail    = 0;
        while (tail < 4 && cyc < 3000) begin
            i_start     = 1'b0;
            i_rf_finish = 1'b0;
            if (o_rf_start) begin
                got_h.push_back(int'(o_h));
                got_w.push_back(int'(o_w));
                got_l.push_back(int'(o_length));
                got_c.push_back(int'(o_col));
                st_cyc.push_back(cyc);
                fin_at = cyc + 5;
                if (poke) i_start = 1'b1;
            end
            if (cyc == fin_at) begin
                i_rf_finish = 1'b1;
                if (poke) spur_at = cyc + 2;
            end
            if (cyc == spur_at) i_rf_finish = 1'b1;
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0) tail++;
            @(posedge clk); #1;
            cyc++;
        end
        i_start     = 1'b0;
        i_rf_finish = 1'b0;
        check_eq("done_count", 32'(done_cnt), 32'd1);
    endtask

    task automatic check_seq(input string tag);
        check_eq({tag, "_starts"}, 32'(got_h.size()), 32'(exp_h.size()));
        for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) begin
            check_eq($sformatf("%s_h%0d", tag, i), 32'(got_h[i]), 32'(exp_h[i]));
            check_eq($sformatf("%s_w%0d", tag, i), 32'(got_w[i]), 32'(exp_w[i]));
            check_eq($sformatf("%s_len%0d", tag, i), 32'(got_l[i]), 32'(exp_l[i]));
            check_eq($sformatf("%s_col%0d", tag, i), 32'(got_c[i]), 32'(exp_c[i]));
        end
    endtask

    task automatic check_perf(input string tag, input int busy, input int iss);
`ifdef ADDR_RF_SCHED_PERF_EN
        check_eq({tag, "_busy_cycles"}, o_busy_cycles, 32'(busy));
        check_eq({tag, "_issue_cnt"}, 32'(o_issue_cnt), 32'(iss));
`else
        if (busy < 0 || iss < 0) $display("perf check %s skipped", tag);
`endif
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!o_rf_start && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_seen"}, 32'(o_rf_start), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) len_tab[i] = 7'd0;
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_stride    = 2'd0;
        i_oh_num    = 8'd0;
        i_ow_num    = 8'd0;
        i_col_num   = 5'd0;
        i_rf_finish = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_done", 32'(o_done), 32'd0);
        check_eq("rst_rf_start", 32'(o_rf_start), 32'd0);
        check_eq("rst_col", 32'(o_col), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 2x3 output, one column, stride 1
        len_tab[0] = 7'd10;
        run_job(1, 2, 3, 1, 1'b0);
        exp_h = '{0, 0, 0, 1, 1, 1};
        exp_w = '{0, 1, 2, 0, 1, 2};
        exp_l = '{10, 10, 10, 10, 10, 10};
        exp_c = '{0, 0, 0, 0, 0, 0};
        check_seq("s1");
        if (st_cyc.size() >= 2) begin
            check_eq("s1_first_start_cyc", 32'(st_cyc[0]), 32'd2);
            check_eq("s1_finish_to_start", 32'(st_cyc[1] - (st_cyc[0] + 5)), 32'd3);
        end
        check_eq("s1_done_cyc", 32'(done_cyc), 32'd50);
        check_eq("s1_busy_after", 32'(o_busy), 32'd0);
        check_perf("s1", 49, 6);

        // stride 2
        run_job(2, 2, 2, 1, 1'b0);
        exp_h = '{0, 0, 2, 2};
        exp_w = '{0, 2, 0, 2};
        exp_l = '{10, 10, 10, 10};
        exp_c = '{0, 0, 0, 0};
        check_seq("s2");
        check_eq("s2_done_cyc", 32'(done_cyc), 32'd34);
        check_perf("s2", 33, 4);

        // three columns, middle one empty
        len_tab[0] = 7'd4;
        len_tab[1] = 7'd0;
        len_tab[2] = 7'd7;
        run_job(1, 1, 1, 3, 1'b0);
        exp_h = '{0, 0};
        exp_w = '{0, 0};
        exp_l = '{4, 7};
        exp_c = '{0, 2};
        check_seq("s3");
        if (st_cyc.size() >= 2) check_eq("s3_second_start_cyc", 32'(st_cyc[1]), 32'd12);
        check_eq("s3_done_cyc", 32'(done_cyc), 32'd20);
        check_perf("s3", 19, 2);

        // i_start re-pulsed in WAIT and spurious finish in ISSUE
        len_tab[0] = 7'd10;
        run_job(1, 2, 3, 1, 1'b1);
        exp_h = '{0, 0, 0, 1, 1, 1};
        exp_w = '{0, 1, 2, 0, 1, 2};
        exp_l = '{10, 10, 10, 10, 10, 10};
        exp_c = '{0, 0, 0, 0, 0, 0};
        check_seq("s4");
        check_eq("s4_done_cyc", 32'(done_cyc), 32'd50);
        check_perf("s4", 49, 6);

        // reset asserted mid-job during WAIT
        i_stride  = 2'd1;
        i_oh_num  = 8'd2;
        i_ow_num  = 8'd3;
        i_col_num = 5'd1;
        i_start   = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_start("s5_start1");
        repeat (5) @(posedge clk);
        #1;
        i_rf_finish = 1'b1;
        @(posedge clk); #1;
        i_rf_finish = 1'b0;
        wait_start("s5_start2");
        check_eq("s5_pre_w", 32'(o_w), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("s5_rst_busy", 32'(o_busy), 32'd0);
        check_eq("s5_rst_w", 32'(o_w), 32'd0);
        check_eq("s5_rst_len", 32'(o_length), 32'd0);
        check_eq("s5_rst_col", 32'(o_col), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("s5_idle_busy", 32'(o_busy), 32'd0);
        check_eq("s5_idle_start", 32'(o_rf_start), 32'd0);
        run_job(1, 1, 1, 1, 1'b0);
        exp_h = '{0};
        exp_w = '{0};
        exp_l = '{10};
        exp_c = '{0};
        check_seq("s5");
        check_eq("s5_done_cyc", 32'(done_cyc), 32'd10);

        // zero output rows: straight to DONE
        run_job(1, 0, 3, 1, 1'b0);
        exp_h.delete(); exp_w.delete(); exp_l.delete(); exp_c.delete();
        check_seq("s6");
        check_eq("s6_done_cyc", 32'(done_cyc), 32'd2);
        check_perf("s6", 1, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
